// File: rtl/fix_defs.sv
// fix_defs: shared constants, state encoding and helpers for the FIX
// transmit framer.
//   FIX_PAYLOAD_LEN   maximum payload bytes per message
//   SOH / ASCII_0 / ASCII_EQ / BEGIN_STR   frame characters
//   HDR_LEN / FIXED_LEN / TRL_LEN          fixed segment lengths
//   fix_state_t       framer FSM states
//   bcd_inc()         6-digit BCD increment, 999999 wraps to 000001
package fix_defs;

    localparam int             FIX_PAYLOAD_LEN = 220;
    localparam logic [7:0]     PAYLOAD_MAX     = 8'd220;

    localparam logic [7:0]     SOH      = 8'h01;
    localparam logic [7:0]     ASCII_0  = 8'h30;
    localparam logic [7:0]     ASCII_EQ = 8'h3D;
    // "8=FIX.4.2"
    localparam logic [71:0]    BEGIN_STR = 72'h38_3D_46_49_58_2E_34_2E_32;

    // "8=FIX.4.2<SOH>9=LLL<SOH>"
    localparam logic [7:0]     HDR_LEN   = 8'd16;
    // "35=T<SOH>34=SSSSSS<SOH>"; also the non-payload part of BodyLength
    localparam logic [7:0]     FIXED_LEN = 8'd15;
    // "10=CCC<SOH>"
    localparam logic [7:0]     TRL_LEN   = 8'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_FIXED   = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_TRAILER = 3'd4
    } fix_state_t;

    // Ripple a +1 through six BCD digits, least significant first.
    // The all-zero result after 999999 is remapped to 000001.
    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] src;
        logic [23:0] res;
        logic [3:0]  d;
        logic        carry;
        src   = v;
        res   = 24'h000000;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = src[3:0];
            if (carry) begin
                if (d == 4'd9) begin
                    d = 4'd0;
                end else begin
                    d     = d + 4'd1;
                    carry = 1'b0;
                end
            end else begin
                d = src[3:0];
            end
            res = {d, res[23:4]};
            src = {4'd0, src[23:4]};
        end
        if (res == 24'h000000) begin
            res = 24'h000001;
        end else begin
            res = res;
        end
        return res;
    endfunction

endpackage

// File: rtl/fix_bin2dec3.sv
// fix_bin2dec3: combinational 8-bit binary to three zero-padded ASCII digits.
//   bin    input  8   value 0..255
//   ascii  output 24  {hundreds, tens, ones} as ASCII characters
module fix_bin2dec3
    import fix_defs::*;
(
    input  logic [7:0]  bin,
    output logic [23:0] ascii
);

    logic [1:0] hund_s;
    logic [3:0] tens_s;
    logic [7:0] rem_s;

    // Peel off hundreds by comparison, then tens by repeated subtraction;
    // what remains is the ones digit.
    always_comb begin
        rem_s  = bin;
        hund_s = 2'd0;
        tens_s = 4'd0;
        if (rem_s >= 8'd200) begin
            hund_s = 2'd2;
            rem_s  = rem_s - 8'd200;
        end else if (rem_s >= 8'd100) begin
            hund_s = 2'd1;
            rem_s  = rem_s - 8'd100;
        end else begin
            hund_s = 2'd0;
        end
        for (int k = 0; k < 9; k++) begin
            if (rem_s >= 8'd10) begin
                rem_s  = rem_s - 8'd10;
                tens_s = tens_s + 4'd1;
            end else begin
                tens_s = tens_s;
            end
        end
        ascii = {ASCII_0 | {6'd0, hund_s},
                 ASCII_0 | {4'd0, tens_s},
                 ASCII_0 | {4'd0, rem_s[3:0]}};
    end

endmodule

// File: rtl/fix_encoder.sv
// fix_encoder: transmit-side FIX framer. Accepts a MsgType and raw payload,
// emits header (with BodyLength), tags 35/34 (with BCD MsgSeqNum), payload
// and CheckSum trailer one byte per cycle over valid/ready.
//   clk, rst_n (sync, active-low)
//   tx_valid/tx_ready, msg_type, payload, payload_len, seq_reset : input side
//   out_valid/out_ready, out_data, out_last                      : byte stream
//   len_error : pulse after accepting an oversize payload_len
//   next_seq  : BCD MsgSeqNum for the next message
module fix_encoder
    import fix_defs::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    input  logic [7:0]                   msg_type,
    input  logic [FIX_PAYLOAD_LEN*8-1:0] payload,
    input  logic [7:0]                   payload_len,
    input  logic                         seq_reset,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   out_data,
    output logic                         out_last,
    output logic                         len_error,
    output logic [23:0]                  next_seq
);

    fix_state_t                   state_r, state_nxt_s;
    logic [7:0]                   idx_r, idx_nxt_s;
    logic                         tx_ready_r, out_valid_r, out_last_r, len_error_r;
    logic [7:0]                   out_data_r, msg_type_r, len_r, csum_r;
    logic [23:0]                  seq_r, seq_lat_r;
    logic [FIX_PAYLOAD_LEN*8-1:0] payload_r, pay_sh_s;
    logic                         accept_s, hs_s, adv_s;
    logic [7:0]                   len_clamp_s, body_len_s, byte_s;
    logic [23:0]                  lll_s, ccc_s;
    logic [127:0]                 hdr_vec_s, hdr_sh_s;
    logic [119:0]                 fix_vec_s, fix_sh_s;
    logic [55:0]                  trl_vec_s, trl_sh_s;

    assign accept_s    = tx_valid && tx_ready_r;
    assign hs_s        = out_valid_r && out_ready;
    assign len_clamp_s = (payload_len > PAYLOAD_MAX) ? PAYLOAD_MAX : payload_len;
    assign body_len_s  = len_r + FIXED_LEN;

    fix_bin2dec3 u_len_digits (.bin(body_len_s), .ascii(lll_s));
    // csum_r no longer changes once TRAILER is entered, so these digits are
    // settled well before the first digit byte is loaded.
    fix_bin2dec3 u_sum_digits (.bin(csum_r),     .ascii(ccc_s));

    assign hdr_vec_s = {BEGIN_STR, SOH, 8'h39, ASCII_EQ, lll_s, SOH};
    assign fix_vec_s = {8'h33, 8'h35, ASCII_EQ, msg_type_r, SOH,
                        8'h33, 8'h34, ASCII_EQ,
                        4'h3, seq_lat_r[23:20], 4'h3, seq_lat_r[19:16],
                        4'h3, seq_lat_r[15:12], 4'h3, seq_lat_r[11:8],
                        4'h3, seq_lat_r[7:4],   4'h3, seq_lat_r[3:0], SOH};
    assign trl_vec_s = {8'h31, 8'h30, ASCII_EQ, ccc_s, SOH};

    // Next segment/index: the pointer moves on accept and on each handshake.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        adv_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_HDR;
                    idx_nxt_s   = 8'd0;
                    adv_s       = 1'b1;
                end else begin
                    adv_s = 1'b0;
                end
            end
            ST_HDR: begin
                if (hs_s) begin
                    adv_s = 1'b1;
                    if (idx_r == HDR_LEN - 8'd1) begin
                        state_nxt_s = ST_FIXED;
                        idx_nxt_s   = 8'd0;
                    end else begin
                        idx_nxt_s = idx_r + 8'd1;
                    end
                end else begin
                    adv_s = 1'b0;
                end
            end
            ST_FIXED: begin
                if (hs_s) begin
                    adv_s = 1'b1;
                    if (idx_r == FIXED_LEN - 8'd1) begin
                        state_nxt_s = (len_r == 8'd0) ? ST_TRAILER : ST_PAYLOAD;
                        idx_nxt_s   = 8'd0;
                    end else begin
                        idx_nxt_s = idx_r + 8'd1;
                    end
                end else begin
                    adv_s = 1'b0;
                end
            end
            ST_PAYLOAD: begin
                if (hs_s) begin
                    adv_s = 1'b1;
                    if (idx_r == len_r - 8'd1) begin
                        state_nxt_s = ST_TRAILER;
                        idx_nxt_s   = 8'd0;
                    end else begin
                        idx_nxt_s = idx_r + 8'd1;
                    end
                end else begin
                    adv_s = 1'b0;
                end
            end
            ST_TRAILER: begin
                if (hs_s) begin
                    adv_s = 1'b1;
                    if (idx_r == TRL_LEN - 8'd1) begin
                        state_nxt_s = ST_IDLE;
                        idx_nxt_s   = 8'd0;
                    end else begin
                        idx_nxt_s = idx_r + 8'd1;
                    end
                end else begin
                    adv_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = 8'd0;
                adv_s       = 1'b1;
            end
        endcase
    end

    // Byte at the next pointer; each segment is a vector shifted so the
    // wanted byte lands in the top lane.
    always_comb begin
        hdr_sh_s = hdr_vec_s << {idx_nxt_s[3:0], 3'b000};
        fix_sh_s = fix_vec_s << {idx_nxt_s[3:0], 3'b000};
        trl_sh_s = trl_vec_s << {idx_nxt_s[3:0], 3'b000};
        pay_sh_s = payload_r << {idx_nxt_s, 3'b000};
        case (state_nxt_s)
            ST_HDR:     byte_s = hdr_sh_s[127:120];
            ST_FIXED:   byte_s = fix_sh_s[119:112];
            ST_PAYLOAD: byte_s = pay_sh_s[FIX_PAYLOAD_LEN*8-1 -: 8];
            ST_TRAILER: byte_s = trl_sh_s[55:48];
            default:    byte_s = 8'h00;
        endcase
    end

    // FSM state, byte pointer and registered output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= 8'd0;
            tx_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            out_last_r  <= 1'b0;
            len_error_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            tx_ready_r  <= (state_nxt_s == ST_IDLE);
            len_error_r <= accept_s && (payload_len > PAYLOAD_MAX);
            if (adv_s) begin
                out_valid_r <= (state_nxt_s != ST_IDLE);
                out_data_r  <= byte_s;
                out_last_r  <= (state_nxt_s == ST_TRAILER) && (idx_nxt_s == TRL_LEN - 8'd1);
            end else begin
                out_valid_r <= out_valid_r;
                out_data_r  <= out_data_r;
                out_last_r  <= out_last_r;
            end
        end
    end

    // Message latch and running checksum of header, tags and payload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msg_type_r <= 8'h00;
            payload_r  <= '0;
            len_r      <= 8'd0;
            csum_r     <= 8'd0;
        end else if (accept_s) begin
            msg_type_r <= msg_type;
            payload_r  <= payload;
            len_r      <= len_clamp_s;
            csum_r     <= 8'd0;
        end else if (hs_s && (state_r != ST_TRAILER) && (state_r != ST_IDLE)) begin
            csum_r <= csum_r + out_data_r;
        end else begin
            csum_r <= csum_r;
        end
    end

    // BCD MsgSeqNum: a seq_reset coincident with accept sends 000001 itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seq_r     <= 24'h000001;
            seq_lat_r <= 24'h000001;
        end else if (accept_s) begin
            if (seq_reset) begin
                seq_lat_r <= 24'h000001;
                seq_r     <= 24'h000002;
            end else begin
                seq_lat_r <= seq_r;
                seq_r     <= bcd_inc(seq_r);
            end
        end else if (seq_reset) begin
            seq_r <= 24'h000001;
        end else begin
            seq_r <= seq_r;
        end
    end

    assign tx_ready  = tx_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign len_error = len_error_r;
    assign next_seq  = seq_r;

endmodule

// File: tb/tb_fix_encoder.sv
module tb_fix_encoder;
    import fix_defs::*;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic                         tx_valid = 1'b0;
    logic                         tx_ready;
    logic [7:0]                   msg_type = 8'h00;
    logic [FIX_PAYLOAD_LEN*8-1:0] payload = '0;
    logic [7:0]                   payload_len = 8'd0;
    logic                         seq_reset = 1'b0;
    logic                         out_valid;
    logic                         out_ready = 1'b1;
    logic [7:0]                   out_data;
    logic                         out_last;
    logic                         len_error;
    logic [23:0]                  next_seq;

    fix_encoder dut (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .msg_type(msg_type), .payload(payload), .payload_len(payload_len),
        .seq_reset(seq_reset), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .len_error(len_error),
        .next_seq(next_seq)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [8:0] exp_q[$];
    logic [7:0] pl[0:FIX_PAYLOAD_LEN-1];
    int         model_seq = 1;
    bit         bp_en = 1'b0;
    int         cyc = 0, first_cyc = 0, last_cyc = 0, last_cnt = 0, le_cnt = 0, frame_bytes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dig(input int v);
        return 8'(48 + v);
    endfunction

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int p;
        r = 24'h0;
        p = 100000;
        for (int i = 0; i < 6; i++) begin
            r = {r[19:0], 4'((v / p) % 10)};
            p = p / 10;
        end
        return r;
    endfunction

    // Reference frame built straight from the textual frame layout.
    task automatic push_frame(input logic [7:0] mt, input int len, input int seq);
        logic [7:0] f[$];
        string bs;
        int sum, p;
        bs = "8=FIX.4.2";
        for (int i = 0; i < bs.len(); i++) f.push_back(bs[i]);
        f.push_back(8'h01); f.push_back("9"); f.push_back("=");
        f.push_back(dig((15 + len) / 100)); f.push_back(dig(((15 + len) / 10) % 10));
        f.push_back(dig((15 + len) % 10)); f.push_back(8'h01);
        f.push_back("3"); f.push_back("5"); f.push_back("="); f.push_back(mt); f.push_back(8'h01);
        f.push_back("3"); f.push_back("4"); f.push_back("=");
        p = 100000;
        for (int i = 0; i < 6; i++) begin f.push_back(dig((seq / p) % 10)); p = p / 10; end
        f.push_back(8'h01);
        for (int i = 0; i < len; i++) f.push_back(pl[i]);
        sum = 0;
        foreach (f[i]) sum += int'(f[i]);
        sum = sum % 256;
        f.push_back("1"); f.push_back("0"); f.push_back("=");
        f.push_back(dig(sum / 100)); f.push_back(dig((sum / 10) % 10)); f.push_back(dig(sum % 10));
        f.push_back(8'h01);
        foreach (f[i]) exp_q.push_back({(i == f.size() - 1) ? 1'b1 : 1'b0, f[i]});
    endtask

    task automatic push_literal(input string s);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == "|") c = 8'h01;
            exp_q.push_back({(i == s.len() - 1) ? 1'b1 : 1'b0, c});
        end
    endtask

    task automatic fill_pl();
        for (int i = 0; i < FIX_PAYLOAD_LEN; i++) pl[i] = 8'($urandom_range(32, 126));
    endtask

    // Offer a message; called at a negedge, returns at the negedge after accept.
    task automatic send(input logic [7:0] mt, input int len, input bit srst, input bit lit);
        int n, use_seq;
        msg_type    = mt;
        payload_len = 8'(len);
        seq_reset   = srst;
        for (int i = 0; i < FIX_PAYLOAD_LEN; i++) payload = {payload[FIX_PAYLOAD_LEN*8-9:0], pl[i]};
        tx_valid = 1'b1;
        n = 0;
        while (tx_ready !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        check("accept_timeout", 32'(n >= 3000), 32'd0);
        use_seq   = srst ? 1 : model_seq;
        model_seq = srst ? 2 : ((model_seq == 999999) ? 1 : model_seq + 1);
        if (lit) push_literal("8=FIX.4.2|9=015|35=0|34=000001|10=200|");
        else     push_frame(mt, (len > FIX_PAYLOAD_LEN) ? FIX_PAYLOAD_LEN : len, use_seq);
        @(negedge clk);
        check("first_byte", 32'({out_valid, out_data}), 32'({1'b1, 8'h38}));
        tx_valid  = 1'b0;
        seq_reset = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin @(negedge clk); n++; end
        check("frame_timeout", 32'(n >= 3000), 32'd0);
        @(negedge clk);
    endtask

    // Random backpressure driver.
    initial begin
        forever begin
            @(negedge clk);
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: samples just after the negedge, after stimulus has settled.
    initial begin : monitor
        logic       prev_stall, prev_valid, prev_last, after_last;
        logic [7:0] prev_data;
        logic [8:0] e;
        prev_stall = 1'b0; prev_valid = 1'b0; prev_last = 1'b0; after_last = 1'b0;
        prev_data = 8'h00;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (!rst_n) begin
                prev_stall = 1'b0; prev_valid = 1'b0; after_last = 1'b0; frame_bytes = 0;
            end else begin
                if (after_last) begin
                    check("idle_after_last", 32'({tx_ready, out_valid}), 32'(2'b10));
                    after_last = 1'b0;
                end
                if (prev_stall)
                    check("stall_hold", 32'({out_valid, out_last, out_data}), 32'({1'b1, prev_last, prev_data}));
                if (out_valid && !prev_valid) first_cyc = cyc;
                if (len_error) le_cnt++;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_byte: got %h, expected no byte", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_byte", 32'({out_last, out_data}), 32'(e));
                    end
                    frame_bytes++;
                    if (out_last) begin
                        last_cnt++; last_cyc = cyc; after_last = 1'b1; frame_bytes = 0;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_valid = out_valid;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int l0, lc, le0;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_outs", 32'({out_valid, out_data, out_last, len_error}), 32'd0);
        check("rst_next_seq", 32'(next_seq), 32'h000001);
        rst_n = 1'b1;
        @(negedge clk);
        check("tx_ready_after_rst", 32'(tx_ready), 32'd1);

        // Heartbeat against the literal frame
        fill_pl();
        send("0", 0, 1'b0, 1'b1);
        wait_done();
        check("hb_next_seq", 32'(next_seq), 32'(to_bcd(model_seq)));

        // Back-to-back: exactly one idle cycle between frames
        fill_pl();
        send("D", int'($urandom_range(0, 40)), 1'b0, 1'b0);
        send("F", int'($urandom_range(0, 40)), 1'b0, 1'b0);
        l0 = last_cyc;
        wait_done();
        check("b2b_gap", 32'(first_cyc - l0), 32'd2);
        check("b2b_next_seq", 32'(next_seq), 32'(to_bcd(model_seq)));

        // Backpressure with 30 bytes, then the same message unstalled
        fill_pl();
        bp_en = 1'b1;
        send("D", 30, 1'b0, 1'b0);
        wait_done();
        bp_en = 1'b0;
        send("D", 30, 1'b0, 1'b0);
        wait_done();

        // Oversize length is clamped and flagged once
        le0 = le_cnt;
        fill_pl();
        send("8", 230, 1'b0, 1'b0);
        wait_done();
        check("len_error_pulses", 32'(le_cnt - le0), 32'd1);

        // Random messages with random backpressure
        le0 = le_cnt;
        for (int k = 0; k < 6; k++) begin
            fill_pl();
            bp_en = 1'($urandom_range(0, 1));
            send(8'($urandom_range(65, 90)), int'($urandom_range(0, 220)), 1'b0, 1'b0);
            wait_done();
        end
        bp_en = 1'b0;
        check("no_len_error", 32'(le_cnt - le0), 32'd0);

        // seq_reset alone returns the counter to 000001
        seq_reset = 1'b1;
        @(negedge clk);
        seq_reset = 1'b0;
        model_seq = 1;
        check("seq_reset_idle", 32'(next_seq), 32'h000001);

        // Wrap from 999999, then seq_reset coincident with accept
        force dut.seq_r = 24'h999999;
        @(negedge clk);
        @(negedge clk);
        release dut.seq_r;
        model_seq = 999999;
        @(negedge clk);
        check("preload_seq", 32'(next_seq), 32'(to_bcd(model_seq)));
        fill_pl();
        send("A", 12, 1'b0, 1'b0);
        wait_done();
        check("wrap_next_seq", 32'(next_seq), 32'h000001);
        send("A", 5, 1'b1, 1'b0);
        wait_done();
        check("srst_accept_next_seq", 32'(next_seq), 32'h000002);

        // Reset in the middle of a frame
        fill_pl();
        send("D", 30, 1'b0, 1'b0);
        lc = 0;
        while (frame_bytes < 20 && lc < 500) begin @(negedge clk); lc++; end
        check("reach_byte20", 32'(lc >= 500), 32'd0);
        lc = last_cnt;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_valid_drop", 32'({out_valid, out_last}), 32'd0);
        rst_n = 1'b1;
        model_seq = 1;
        @(negedge clk);
        check("abort_next_seq", 32'(next_seq), 32'h000001);
        fill_pl();
        send("D", 17, 1'b0, 1'b0);
        wait_done();
        check("abort_one_last", 32'(last_cnt - lc), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
